// File: rtl/fft8_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fft8_stage_sequencer
//  Purpose  : Control sequencer for an in-place, memory-based N-point FFT that
//             time-shares one 8-lane butterfly across LOG2_N/3 passes.
//             Phases: LOAD (frame into vector RAM), COMPUTE/DRAIN per pass
//             (read, butterfly, write back), UNLOAD (streamed readout).
//             Holds no sample data; only addresses, enables and strobes.
//  Ports    : i_clock, i_reset (sync, active-high)
//             i_in_valid / o_in_ready      - input vector handshake
//             o_out_valid / i_out_ready    - output vector handshake
//             o_out_last                   - final output vector of frame
//             o_mem_wr_en/_addr, o_wr_sel  - RAM write port + data mux select
//             o_mem_rd_en/_addr            - RAM read port (1-cycle read)
//             o_btfly_valid, o_stage,
//             o_tw_addr                    - butterfly strobe, pass, twiddle
//             o_busy, o_done               - status
//  Option   : FFT_SEQ_PERF_EN adds o_frame_cnt and o_frame_cycles counters.
//  Revision : 1.0 - initial release
// ============================================================================
module fft8_stage_sequencer #(
    parameter int  LOG2_N    = 6,
    parameter int  N_STAGES  = 2,
    parameter int  NB_STAGE  = 1,
    parameter int  BTFLY_LAT = 1,
    localparam int NB_ADDR   = LOG2_N - 3
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic                         i_out_ready,
    output logic                         o_out_valid,
    output logic                         o_out_last,
    output logic                         o_mem_wr_en,
    output logic [NB_ADDR-1:0]           o_mem_wr_addr,
    output logic                         o_wr_sel,
    output logic                         o_mem_rd_en,
    output logic [NB_ADDR-1:0]           o_mem_rd_addr,
    output logic                         o_btfly_valid,
    output logic [NB_STAGE-1:0]          o_stage,
    output logic [NB_STAGE+NB_ADDR-1:0]  o_tw_addr,
    output logic                         o_busy,
    output logic                         o_done
`ifdef FFT_SEQ_PERF_EN
    ,
    output logic [15:0]                  o_frame_cnt,
    output logic [15:0]                  o_frame_cycles
`endif
);

    localparam int c_NVEC  = 1 << NB_ADDR;
    localparam int c_CW    = NB_ADDR + 1;     // counter reaches c_NVEC in UNLOAD
    localparam int c_DEPTH = 1 + BTFLY_LAT;   // read -> write-back distance
    localparam logic [c_CW-1:0]     c_LAST_VEC   = c_CW'(c_NVEC - 1);
    localparam logic [c_CW-1:0]     c_NVEC_CNT   = c_CW'(c_NVEC);
    localparam logic [NB_STAGE-1:0] c_LAST_STAGE = NB_STAGE'(N_STAGES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_DRAIN   = 3'd3,
        S_UNLOAD  = 3'd4
    } state_t;

    state_t              r_state_q, w_state_d;
    logic [c_CW-1:0]     r_cnt_q, w_cnt_d;       // load count / block / unload count
    logic [NB_STAGE-1:0] r_stage_q, w_stage_d;
    logic                r_ov_q, w_ov_d;
    logic                r_last_q, w_last_d;
    logic                r_done_q, w_done_d;

    // Write-back pipe: index 0 is the stage right after the RAM read,
    // index c_DEPTH-1 drives the RAM write port.
    logic [c_DEPTH-1:0]  r_pv_q;
    logic [NB_ADDR-1:0]  r_pa_q [c_DEPTH];

    logic w_rd_en;
    logic w_cmp_rd;
    logic w_wr_load;
    logic w_pipe_busy;
    logic w_out_accept;

    // Entries still in flight after this cycle's write; the final stage is
    // being written now and does not block the next pass.
    always_comb begin
        w_pipe_busy = 1'b0;
        for (int k = 0; k < c_DEPTH - 1; k++) begin
            w_pipe_busy = w_pipe_busy | r_pv_q[k];
        end
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_stage_d    = r_stage_q;
        w_ov_d       = r_ov_q;
        w_last_d     = r_last_q;
        w_done_d     = 1'b0;
        w_rd_en      = 1'b0;
        w_cmp_rd     = 1'b0;
        w_wr_load    = 1'b0;
        w_out_accept = r_ov_q & i_out_ready;
        case (r_state_q)
            S_IDLE: begin
                if (i_in_valid) begin
                    w_wr_load = 1'b1;
                    if (c_NVEC == 1) begin
                        w_state_d = S_COMPUTE;
                        w_cnt_d   = '0;
                        w_stage_d = '0;
                    end else begin
                        w_state_d = S_LOAD;
                        w_cnt_d   = c_CW'(1);
                    end
                end
            end
            S_LOAD: begin
                if (i_in_valid) begin
                    w_wr_load = 1'b1;
                    if (r_cnt_q == c_LAST_VEC) begin
                        w_state_d = S_COMPUTE;
                        w_cnt_d   = '0;
                        w_stage_d = '0;
                    end else begin
                        w_cnt_d = r_cnt_q + c_CW'(1);
                    end
                end
            end
            S_COMPUTE: begin
                w_rd_en  = 1'b1;
                w_cmp_rd = 1'b1;
                if (r_cnt_q == c_LAST_VEC) begin
                    w_state_d = S_DRAIN;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt_q + c_CW'(1);
                end
            end
            S_DRAIN: begin
                // Holding here until the pipe empties keeps every read of
                // pass s+1 behind the last write of pass s.
                if (!w_pipe_busy) begin
                    if (r_stage_q < c_LAST_STAGE) begin
                        w_stage_d = r_stage_q + NB_STAGE'(1);
                        w_state_d = S_COMPUTE;
                    end else begin
                        w_state_d = S_UNLOAD;
                    end
                    w_cnt_d = '0;
                end
            end
            S_UNLOAD: begin
                w_rd_en = (r_cnt_q < c_NVEC_CNT) && (!r_ov_q || i_out_ready);
                if (w_rd_en) begin
                    w_cnt_d  = r_cnt_q + c_CW'(1);
                    w_ov_d   = 1'b1;
                    w_last_d = (r_cnt_q == c_LAST_VEC);
                end else if (w_out_accept) begin
                    w_ov_d   = 1'b0;
                    w_last_d = 1'b0;
                end
                if (w_out_accept && r_last_q) begin
                    w_state_d = S_IDLE;
                    w_cnt_d   = '0;
                    w_stage_d = '0;
                    w_done_d  = 1'b1;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= '0;
            r_stage_q <= '0;
            r_ov_q    <= 1'b0;
            r_last_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_stage_q <= w_stage_d;
            r_ov_q    <= w_ov_d;
            r_last_q  <= w_last_d;
            r_done_q  <= w_done_d;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pv_q <= '0;
            for (int k = 0; k < c_DEPTH; k++) begin
                r_pa_q[k] <= '0;
            end
        end else begin
            r_pv_q[0] <= w_cmp_rd;
            r_pa_q[0] <= r_cnt_q[NB_ADDR-1:0];
            for (int k = 1; k < c_DEPTH; k++) begin
                r_pv_q[k] <= r_pv_q[k-1];
                r_pa_q[k] <= r_pa_q[k-1];
            end
        end
    end

    assign o_in_ready    = (r_state_q == S_IDLE) || (r_state_q == S_LOAD);
    assign o_busy        = (r_state_q != S_IDLE);
    assign o_out_valid   = r_ov_q;
    assign o_out_last    = r_last_q;
    assign o_done        = r_done_q;
    assign o_mem_rd_en   = w_rd_en;
    assign o_mem_rd_addr = w_rd_en ? r_cnt_q[NB_ADDR-1:0] : '0;
    assign o_mem_wr_en   = w_wr_load | r_pv_q[c_DEPTH-1];
    assign o_mem_wr_addr = w_wr_load            ? r_cnt_q[NB_ADDR-1:0] :
                           r_pv_q[c_DEPTH-1]    ? r_pa_q[c_DEPTH-1]    : '0;
    assign o_wr_sel      = r_pv_q[c_DEPTH-1];
    assign o_btfly_valid = r_pv_q[0];
    // Stage is constant while the pipe holds entries, so the live register
    // lines up with the butterfly strobe.
    assign o_stage       = r_pv_q[0] ? r_stage_q : '0;
    assign o_tw_addr     = r_pv_q[0] ? {r_stage_q, r_pa_q[0]} : '0;

`ifdef FFT_SEQ_PERF_EN
    logic [15:0] r_cyc_q;
    logic [15:0] w_cyc_inc;
    logic [15:0] r_frame_cnt_q;
    logic [15:0] r_frame_cycles_q;

    assign w_cyc_inc = (r_cyc_q == 16'hFFFF) ? r_cyc_q : r_cyc_q + 16'd1;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cyc_q          <= '0;
            r_frame_cnt_q    <= '0;
            r_frame_cycles_q <= '0;
        end else begin
            // The first accept counts as cycle 1; the done cycle is included.
            if (r_state_q == S_IDLE && i_in_valid) begin
                r_cyc_q <= 16'd1;
            end else if (r_state_q != S_IDLE) begin
                r_cyc_q <= w_cyc_inc;
            end
            if (r_done_q) begin
                r_frame_cnt_q    <= r_frame_cnt_q + 16'd1;
                r_frame_cycles_q <= w_cyc_inc;
            end
        end
    end

    assign o_frame_cnt    = r_frame_cnt_q;
    assign o_frame_cycles = r_frame_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft8_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft8_stage_sequencer
//  Purpose  : Self-checking bench for fft8_stage_sequencer at default sizing
//             (N = 64, two passes, BTFLY_LAT = 1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fft8_stage_sequencer;

    localparam int c_LAT    = 1;
    localparam int c_PASS   = 9 + c_LAT;          // N/8 + 1 + BTFLY_LAT
    localparam int c_UNLOAD = 2 * c_PASS;         // unload start, rel. compute start
    localparam int c_DONE_T = c_UNLOAD + 9;
    localparam logic [19:0] c_IDLE = 20'h80000;   // only o_in_ready high

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready, out_valid, out_last, wr_en, wr_sel, rd_en;
    logic       btfly_valid, busy, done;
    logic [2:0] wr_addr, rd_addr;
    logic [0:0] stage;
    logic [3:0] tw_addr;
`ifdef FFT_SEQ_PERF_EN
    logic [15:0] frame_cnt, frame_cycles;
`endif

    always #5 clk = ~clk;

    fft8_stage_sequencer #(
        .LOG2_N(6), .N_STAGES(2), .NB_STAGE(1), .BTFLY_LAT(c_LAT)
    ) dut (
        .i_clock(clk), .i_reset(rst),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_out_ready(out_ready), .o_out_valid(out_valid), .o_out_last(out_last),
        .o_mem_wr_en(wr_en), .o_mem_wr_addr(wr_addr), .o_wr_sel(wr_sel),
        .o_mem_rd_en(rd_en), .o_mem_rd_addr(rd_addr),
        .o_btfly_valid(btfly_valid), .o_stage(stage), .o_tw_addr(tw_addr),
        .o_busy(busy), .o_done(done)
`ifdef FFT_SEQ_PERF_EN
        , .o_frame_cnt(frame_cnt), .o_frame_cycles(frame_cycles)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          kcyc = 0;
    logic [19:0] smp;
    logic [2:0]  model_rdata = 3'd0;
    int          acc_n = 0;
    int          acc_idx [16];
    logic        acc_last [16];
    int          done_cnt = 0;
    int          last_lat = 0;

    typedef struct {
        logic        v;
        logic [19:0] exp;
    } vec_t;
    vec_t ld_tab [16];

    function automatic logic [19:0] mk(input logic ir, input logic bz, input logic we,
                                       input logic [2:0] wa, input logic ws, input logic re,
                                       input logic [2:0] ra, input logic bv, input logic st,
                                       input logic [3:0] tw, input logic ov, input logic ol,
                                       input logic dn);
        return {ir, bz, we, wa, ws, re, ra, bv, st, tw, ov, ol, dn};
    endfunction

    // Expected outputs for a frame with ready always high; t is relative to
    // the first COMPUTE cycle, negative t is a back-to-back load.
    function automatic logic [19:0] exp_frame(input int t);
        logic ir = 0, bz = 1, we = 0, ws = 0, re = 0, bv = 0, st = 0, ov = 0, ol = 0, dn = 0;
        logic [2:0] wa = 0, ra = 0;
        logic [3:0] tw = 0;
        int kk;
        if (t < 0) begin
            ir = 1; we = 1; wa = 3'(t + 8); bz = (t > -8);
        end else begin
            for (int p = 0; p < 2; p++) begin
                kk = t - c_PASS * p;
                if (kk >= 0 && kk < 8) begin re = 1; ra = 3'(kk); end
                if (kk >= 1 && kk <= 8) begin bv = 1; st = p[0]; tw = {p[0], 3'(kk - 1)}; end
                if (kk >= 1 + c_LAT && kk <= 8 + c_LAT) begin
                    we = 1; ws = 1; wa = 3'(kk - 1 - c_LAT);
                end
            end
            kk = t - c_UNLOAD;
            if (kk >= 0 && kk < 8) begin re = 1; ra = 3'(kk); end
            if (kk >= 1 && kk <= 8) ov = 1;
            if (kk == 8) ol = 1;
            if (t >= c_DONE_T) begin bz = 0; ir = 1; end
            dn = (t == c_DONE_T);
        end
        return mk(ir, bz, we, wa, ws, re, ra, bv, st, tw, ov, ol, dn);
    endfunction

    // One clock: drive inputs, sample settled outputs, update RAM read model
    // and accept log, then advance past the next rising edge.
    task automatic step(input logic v, input logic r);
        in_valid  = v;
        out_ready = r;
        #2;
        smp = {in_ready, busy, wr_en, wr_addr, wr_sel, rd_en, rd_addr,
               btfly_valid, stage, tw_addr, out_valid, out_last, done};
        if (out_valid && out_ready) begin
            if (acc_n < 16) begin
                acc_idx[acc_n]  = int'(model_rdata);
                acc_last[acc_n] = out_last;
            end
            acc_n++;
        end
        if (rd_en) model_rdata = rd_addr;
        if (done) done_cnt++;
        @(posedge clk);
        #1;
        kcyc++;
    endtask

    task automatic chk(input string nm, input int t, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%h expected=%h", nm, t, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic clr_log();
        acc_n    = 0;
        done_cnt = 0;
    endtask

    task automatic chk_outputs(input string nm);
        chk_int({nm, "_count"}, acc_n, 8);
        for (int i = 0; i < 8 && i < acc_n; i++) begin
            chk_int({nm, "_idx"}, acc_idx[i], i);
            chk_int({nm, "_last"}, int'(acc_last[i]), (i == 7) ? 1 : 0);
        end
        chk_int({nm, "_done"}, done_cnt, 1);
    endtask

    task automatic run_b2b(input string nm);
        int ka, kd;
        ka = kcyc;
        kd = -1;
        clr_log();
        for (int t = -8; t <= c_DONE_T + 1; t++) begin
            step(t < 0, 1'b1);
            if (smp[0] && kd < 0) kd = kcyc - 1;
            chk(nm, t, smp, exp_frame(t));
        end
        last_lat = kd - ka + 1;
        chk_outputs(nm);
    endtask

    initial begin
        // Reset
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1);
            chk("reset_state", i, smp, c_IDLE);
        end

        // Back-to-back frame: addresses, pass timing, twiddles, outputs
        run_b2b("b2b");

        // Toggling input valid: table-driven load phase then the same frame
        for (int i = 0; i < 15; i++) begin
            ld_tab[i].v   = (i % 2 == 0);
            ld_tab[i].exp = mk(1'b1, i > 0, ld_tab[i].v, ld_tab[i].v ? 3'(i / 2) : 3'd0,
                               1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        end
        ld_tab[15].v   = 1'b0;
        ld_tab[15].exp = mk(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0,
                            1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        clr_log();
        for (int i = 0; i < 16; i++) begin
            step(ld_tab[i].v, 1'b1);
            chk("toggle_load", i, smp, ld_tab[i].exp);
        end
        for (int t = 1; t <= c_DONE_T + 1; t++) begin
            step(1'b0, 1'b1);
            chk("toggle_frame", t, smp, exp_frame(t));
        end
        chk_outputs("toggle");

        // Downstream backpressure right after the first output
        begin
            logic seen;
            clr_log();
            seen = 1'b0;
            for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
            for (int w = 0; w < 100 && !seen; w++) begin
                step(1'b0, 1'b1);
                seen = smp[2];
            end
            chk_int("bp_first_out", int'(seen), 1);
            for (int i = 0; i < 5; i++) begin
                step(1'b0, 1'b0);
                chk("bp_hold", i, {18'd0, smp[2], smp[12]}, 20'd2);
            end
            for (int w = 0; w < 100 && done_cnt == 0; w++) step(1'b0, 1'b1);
            step(1'b0, 1'b1);
            chk("bp_end_idle", 0, smp, c_IDLE);
            chk_outputs("bp");
        end

        // Reset in COMPUTE at stage 1, block 3
        clr_log();
        for (int t = -8; t < 13; t++) step(t < 0, 1'b1);
        rst = 1'b1;
        step(1'b0, 1'b1);
        chk("rst_cycle", 13, smp, exp_frame(13));
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            chk("rst_idle", i, smp, c_IDLE);
        end
        chk_int("rst_no_done", done_cnt, 0);
        run_b2b("after_rst");

`ifdef FFT_SEQ_PERF_EN
        run_b2b("perf2");
        step(1'b0, 1'b1);
        chk_int("frame_cnt", int'(frame_cnt), 2);
        chk_int("frame_cycles", int'(frame_cycles), last_lat);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
